// File: rtl/hamming_secded_decoder.sv
// SECDED decoder engine: reads NUM_WORDS 16-bit codewords, corrects single errors, flags doubles, writes 11-bit results.
// Latency 5 cycles per word plus a one-cycle ack; no backpressure, memory is assumed to answer combinationally.
module hamming_secded_decoder #(
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 94,
    parameter int NUM_WORDS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic [5:0] n_single,
    output logic [5:0] n_double
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DEC, WR_LO, WR_HI, DONE} state_t;

    state_t      state;
    logic [5:0]  word_idx;
    logic [7:0]  lo_q, hi_q;
    logic [7:0]  res_lo, res_hi;

    logic [15:0] code_w, fixed_w;
    logic [3:0]  syndrome;
    logic        parity, is_single, is_double;
    logic [7:0]  dec_lo, dec_hi;
    logic [7:0]  src_addr, dst_addr;

    always_comb begin
        code_w   = {hi_q, lo_q};
        syndrome = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (code_w[k]) syndrome = syndrome ^ 4'(k);
        end
        parity    = ^code_w;
        is_single = parity;
        is_double = !parity && (syndrome != 4'd0);
        // Syndrome 0 with odd parity means only p16 flipped, so the mask lands on w0 harmlessly.
        fixed_w   = parity ? (code_w ^ (16'd1 << syndrome)) : code_w;
        dec_lo    = {fixed_w[12:9], fixed_w[7:5], fixed_w[3]};
        dec_hi    = {is_double, 4'b0000, fixed_w[15:13]};
    end

    assign src_addr = 8'(SRC_BASE) + {1'b0, word_idx, 1'b0};
    assign dst_addr = 8'(DST_BASE) + {1'b0, word_idx, 1'b0};

    always_comb begin
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        case (state)
            RD_LO: mem_addr = src_addr;
            RD_HI: mem_addr = src_addr + 8'd1;
            WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = res_lo;
            end
            WR_HI: begin
                mem_addr    = dst_addr + 8'd1;
                mem_wr_en   = 1'b1;
                mem_wr_data = res_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= 6'd0;
            lo_q     <= 8'd0;
            hi_q     <= 8'd0;
            res_lo   <= 8'd0;
            res_hi   <= 8'd0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            n_single <= 6'd0;
            n_double <= 6'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= RD_LO;
                        word_idx <= 6'd0;
                        n_single <= 6'd0;
                        n_double <= 6'd0;
                        busy     <= 1'b1;
                    end
                end
                RD_LO: begin
                    lo_q  <= mem_rd_data;
                    state <= RD_HI;
                end
                RD_HI: begin
                    hi_q  <= mem_rd_data;
                    state <= DEC;
                end
                DEC: begin
                    res_lo <= dec_lo;
                    res_hi <= dec_hi;
                    if (is_single) n_single <= n_single + 6'd1;
                    if (is_double) n_double <= n_double + 6'd1;
                    state <= WR_LO;
                end
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    if (word_idx == 6'(NUM_WORDS - 1)) begin
                        state <= DONE;
                        ack   <= 1'b1;
                    end else begin
                        word_idx <= word_idx + 6'd1;
                        state    <= RD_LO;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed-vector bench for hamming_secded_decoder with a byte-wide memory model and a brute-force decode reference.
module tb_hamming_secded_decoder;

    localparam int SRC = 64;
    localparam int DST = 94;
    localparam int NW  = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       ack, busy, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic [5:0] n_single, n_double;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail = 0;
    int ack_count = 0;
    int bad_writes = 0;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    vec_t       tbl [NW];
    logic [7:0] exp_lo [NW];
    logic [7:0] exp_hi [NW];

    hamming_secded_decoder #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .n_single(n_single), .n_double(n_double)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            mem[mem_addr] <= mem_wr_data;
            if (int'(mem_addr) < DST || int'(mem_addr) > DST + 2*NW - 1) bad_writes++;
        end
        if (ack === 1'b1) ack_count++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int dpos(input int j);
        int p [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        return p[j];
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic x;
        w = 16'd0;
        for (int j = 0; j < 11; j++) w[dpos(j)] = d[j];
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int k = 1; k < 16; k++)
                if (((k >> b) & 1) == 1 && k != (1 << b)) x = x ^ w[k];
            w[1 << b] = x;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[dpos(j)];
        return d;
    endfunction

    // Nearest-codeword search: valid word, any single flip making it valid, or uncorrectable.
    task automatic ref_decode(input logic [15:0] w, output logic [7:0] lo, output logic [7:0] hi);
        logic [15:0] w2;
        logic [10:0] d;
        logic        f;
        logic        found;
        d = extract(w);
        f = 1'b0;
        if (encode(d) != w) begin
            found = 1'b0;
            for (int j = 0; j < 16; j++) begin
                w2 = w ^ (16'd1 << j);
                if (!found && encode(extract(w2)) == w2) begin
                    found = 1'b1;
                    d = extract(w2);
                end
            end
            if (!found) f = 1'b1;
        end
        lo = d[7:0];
        hi = {f, 4'b0000, d[10:8]};
    endtask

    task automatic load_words(input logic [15:0] ws [NW]);
        for (int i = 0; i < NW; i++) begin
            mem[SRC + 2*i]     = ws[i][7:0];
            mem[SRC + 2*i + 1] = ws[i][15:8];
        end
        for (int a = DST; a < DST + 2*NW; a++) mem[a] = 8'hEE;
    endtask

    task automatic start_run();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 1;
        while (ack !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_results(input string tag, input int es, input int ed);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s lo[%0d]", tag, i), 32'(mem[DST + 2*i]), 32'(exp_lo[i]));
            check($sformatf("%s hi[%0d]", tag, i), 32'(mem[DST + 2*i + 1]), 32'(exp_hi[i]));
        end
        check({tag, " n_single"}, 32'(n_single), 32'(es));
        check({tag, " n_double"}, 32'(n_double), 32'(ed));
        check({tag, " bad_writes"}, 32'(bad_writes), 32'd0);
    endtask

    initial begin
        logic [15:0] ws [NW];
        logic [15:0] w;
        int          cyc, acks0, es, ed, nf, f1, f2;

        tbl[0]  = '{16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{16'hFFFF, 8'hFF, 8'h07};
        tbl[2]  = '{16'h0020, 8'h00, 8'h00};
        tbl[3]  = '{16'h7FFF, 8'hFF, 8'h07};
        tbl[4]  = '{16'h0001, 8'h00, 8'h00};
        tbl[5]  = '{16'h0010, 8'h00, 8'h00};
        tbl[6]  = '{16'h0006, 8'h00, 8'h80};
        tbl[7]  = '{16'h000F, 8'h01, 8'h00};
        tbl[8]  = '{16'h8117, 8'h00, 8'h04};
        tbl[9]  = '{16'h0116, 8'h00, 8'h80};
        tbl[10] = '{16'h020F, 8'h01, 8'h00};
        for (int i = 11; i < NW; i++) tbl[i] = '{16'h0000, 8'h00, 8'h00};

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst ack", 32'(ack), 0);
        check("rst busy", 32'(busy), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst mem_wr_en", 32'(mem_wr_en), 0);
        check("rst mem_wr_data", 32'(mem_wr_data), 0);
        check("rst n_single", 32'(n_single), 0);
        check("rst n_double", 32'(n_double), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table run: clean, single data/parity flips, doubles
        for (int i = 0; i < NW; i++) begin
            ws[i] = tbl[i].w;
            exp_lo[i] = tbl[i].lo;
            exp_hi[i] = tbl[i].hi;
        end
        load_words(ws);
        acks0 = ack_count;
        start_run();
        check("tbl busy after req", 32'(busy), 1);
        wait_ack(cyc);
        check("tbl ack latency", 32'(cyc), 76);
        @(negedge clk);
        check("tbl ack one cycle", 32'(ack), 0);
        check("tbl busy after done", 32'(busy), 0);
        repeat (5) @(negedge clk);
        check("tbl ack count", 32'(ack_count - acks0), 1);
        check_results("tbl", 5, 2);

        // Random encoded words with 0, 1 or 2 injected flips
        es = 0;
        ed = 0;
        for (int i = 0; i < NW; i++) begin
            w  = encode(11'($urandom));
            nf = $urandom_range(0, 2);
            f1 = $urandom_range(0, 15);
            f2 = (f1 + $urandom_range(1, 15)) % 16;
            if (nf >= 1) w = w ^ (16'd1 << f1);
            if (nf == 2) w = w ^ (16'd1 << f2);
            if (nf == 1) es++;
            if (nf == 2) ed++;
            ws[i] = w;
            ref_decode(w, exp_lo[i], exp_hi[i]);
        end
        load_words(ws);
        acks0 = ack_count;
        start_run();
        wait_ack(cyc);
        check("rnd ack latency", 32'(cyc), 76);
        repeat (3) @(negedge clk);
        check("rnd ack count", 32'(ack_count - acks0), 1);
        check_results("rnd", es, ed);

        // Reset in cycle 30 of a run, then a clean rerun
        for (int i = 0; i < NW; i++) begin
            ws[i] = tbl[i].w;
            exp_lo[i] = tbl[i].lo;
            exp_hi[i] = tbl[i].hi;
        end
        load_words(ws);
        acks0 = ack_count;
        start_run();
        repeat (29) @(negedge clk);
        check("pre-reset n_single nonzero", 32'(n_single != 6'd0), 1);
        reset = 1'b1;
        #1;
        check("mid-rst busy", 32'(busy), 0);
        check("mid-rst ack", 32'(ack), 0);
        check("mid-rst n_single", 32'(n_single), 0);
        check("mid-rst n_double", 32'(n_double), 0);
        check("mid-rst mem_wr_en", 32'(mem_wr_en), 0);
        check("mid-rst mem_addr", 32'(mem_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("mid-rst no ack", 32'(ack_count - acks0), 0);
        load_words(ws);
        start_run();
        wait_ack(cyc);
        check("post-rst ack latency", 32'(cyc), 76);
        @(negedge clk);
        check_results("post-rst", 5, 2);

        // req re-pulsed while busy must not lengthen or repeat the run
        acks0 = ack_count;
        load_words(ws);
        start_run();
        cyc = 1;
        while (ack !== 1'b1 && cyc < 400) begin
            req = (cyc == 10 || cyc == 40) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
        check("repulse ack latency", 32'(cyc), 76);
        repeat (20) @(negedge clk);
        check("repulse ack count", 32'(ack_count - acks0), 1);
        check("repulse idle busy", 32'(busy), 0);
        check_results("repulse", 5, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
